// File: rtl/dcim_bitserial_mac.sv
// Bit-serial compute-in-memory MAC: N_CH weight words, one input bit-plane per cycle, shift-add accumulate.
// Optional DCIM_RELU_EN clamps negative signed results to zero when loading nout.
//
// state | meaning
// IDLE  | weights writable, waiting for start
// RUN   | one bit-plane per cycle, MSB first, until plane counter reaches 0
module dcim_bitserial_mac #(
    parameter int N_CH  = 8,
    parameter int WBITS = 8,
    parameter int XBITS = 8,
    localparam int OUTW = WBITS + XBITS + $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_CH-1:0]         WA,
    input  logic [WBITS-1:0]        D,
    input  logic                    start,
    input  logic                    sgn,
    input  logic                    prec,
    input  logic [N_CH*XBITS-1:0]   xin,
    output logic [OUTW-1:0]         nout,
    output logic                    st,
    output logic                    busy
);
    localparam int CW = (XBITS > 2) ? $clog2(XBITS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [WBITS-1:0]  w   [N_CH];
    logic [XBITS-1:0]  x_q [N_CH];
    logic              sgn_q;
    logic              first;
    logic [CW-1:0]     cnt;
    logic [OUTW-1:0]   acc;
    logic [OUTW-1:0]   pp;
    logic [OUTW-1:0]   acc_next;
    logic [OUTW-1:0]   res;

    // Channels are left-aligned at latch time so the current plane is always the channel MSB.
    always_comb begin
        pp = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (x_q[c][XBITS-1]) begin
                pp = pp + {{(OUTW-WBITS){sgn_q & w[c][WBITS-1]}}, w[c]};
            end
        end
    end

    always_comb begin
        acc_next = (first && sgn_q) ? ('0 - pp) : ((acc << 1) + pp);
`ifdef DCIM_RELU_EN
        res = (sgn_q && acc_next[OUTW-1]) ? '0 : acc_next;
`else
        res = acc_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            for (int c = 0; c < N_CH; c++) begin
                w[c]   <= '0;
                x_q[c] <= '0;
            end
            sgn_q <= 1'b0;
            first <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            nout  <= '0;
            st    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            st <= 1'b0;
            case (state)
                IDLE: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (WA[c]) begin
                            w[c] <= D;
                        end
                    end
                    if (start) begin
                        for (int c = 0; c < N_CH; c++) begin
                            x_q[c] <= prec ? (xin[c*XBITS +: XBITS] << (XBITS/2))
                                           : xin[c*XBITS +: XBITS];
                        end
                        sgn_q <= sgn;
                        first <= 1'b1;
                        cnt   <= prec ? CW'(XBITS/2 - 1) : CW'(XBITS - 1);
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int c = 0; c < N_CH; c++) begin
                        x_q[c] <= x_q[c] << 1;
                    end
                    acc   <= acc_next;
                    first <= 1'b0;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        nout  <= res;
                        st    <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dcim_bitserial_mac.md
# dcim_bitserial_mac

Parametrised bit-serial digital compute-in-memory MAC macro, the next generation of the DCIM top: N_CH weight words with one-hot write addressing, an N_CH-channel input vector processed one bit-plane per cycle, and a shift-add accumulator. It adds runtime signed/unsigned mode, runtime full/half input precision, a busy flag, and a single-cycle done pulse. It sits under the DCIM top, between the weight-load path and the output collector.

## Interface

- N_CH, 8, number of channels / weight words (≥2)
- WBITS, 8, weight word width
- XBITS, 8, input width per channel (even, ≥2)
- OUTW, WBITS+XBITS+$clog2(N_CH), result width (derived, not overridden)

- clk  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- WA  in  N_CH  one-hot weight write address; bit i set writes word i
- D  in  WBITS  weight write data
- start  in  1  compute request, sampled in IDLE
- sgn  in  1  1 = two's-complement weights and inputs; 0 = unsigned
- prec  in  1  0 = XBITS input bits; 1 = low XBITS/2 bits per channel
- xin  in  N_CH*XBITS  input vector; channel c = xin[c*XBITS +: XBITS]
- nout  out  OUTW  signed result when sgn=1, else unsigned
- st  out  1  done pulse, one cycle
- busy  out  1  high while computing

## Operation

- States: IDLE, RUN. Reset → IDLE, weights all 0, nout=0, st=0, busy=0, accumulator 0.
- Weight write: in IDLE, every word i with WA[i]=1 takes D on the edge (multiple bits = multicast; WA=0 = no write). In RUN, writes are ignored.
- IDLE, start=1: latch xin, sgn, prec; clear accumulator; load plane counter with P-1 (P = XBITS, or XBITS/2 when prec=1); → RUN; busy=1.
- Same-edge write and start in IDLE: write is applied; the computation uses the new weight.
- RUN, each cycle processes one bit-plane, MSB first (bit P-1 down to 0 of each latched channel):
  - pp = sum over c of w[c] where plane bit of channel c is 1. With sgn=1 weights are sign-extended to OUTW.
  - acc ← (acc<<1) + pp; with sgn=1, the first plane (sign plane, bit P-1) uses acc ← −pp.
- On the last plane (counter 0): nout ← final acc value, st ← 1, busy ← 0, → IDLE.
- start while busy is ignored (no queueing). xin/sgn/prec changes during RUN have no effect.
- nout holds its value until the next completion.
- All arithmetic is in OUTW bits. The result is exact for every legal operand; no overflow is possible by construction.
- rstn=0 mid-RUN: abort at the edge, all state returns to reset values, and no st is produced.

## Timing

- Start accepted at edge T0: busy high from T0+; planes at edges T0+1 … T0+P; nout valid and st high for exactly the cycle after edge T0+P.
- Latency from start edge to st: P cycles (8 full / 4 half at defaults). Throughput: one result per P+1 cycles (start may be asserted again in the st cycle).
- st is registered and never asserted for two consecutive cycles.
- Weight writes take one edge; a word written at edge T is usable by a start at edge T or later.

## Configuration

- DCIM_RELU_EN defined: when sgn=1 and the final result is negative, nout is loaded with 0; positive results and unsigned mode are unchanged. Adds one compare on the final-plane path; latency unchanged.
- DCIM_RELU_EN undefined: nout is always the raw two's-complement/unsigned result.

## Test plan

- Unsigned full: write words 0..7 = 9..16 via WA = 1<<i; xin all channels 0x0A, sgn=0, prec=0, start → st exactly 8 cycles after the start edge, nout=1000, busy low in the st cycle.
- Signed full: all weights 0xFF (−1), all inputs 0x03, sgn=1 → nout = −24 (OUTW two's complement); with DCIM_RELU_EN → nout=0.
- Signed half precision: all weights 0x02, inputs 0xAF (low nibble 0xF = −1), sgn=1, prec=1 → st after 4 cycles, nout = −16; same inputs with sgn=0 → nout = 240.
- Multicast and blocked writes: WA=8'hFF, D=1 → all words 1; xin all 0xFF, unsigned → 2040. Assert WA=8'h01, D=0x55 during RUN → result unchanged and word 0 still 1 afterwards.
- Back-to-back and ignored start: hold start high through RUN → exactly one result per 9 cycles; second result nout matches the first for unchanged operands.
- Reset mid-RUN: rstn=0 at plane 3 → next cycle nout=0, st=0, busy=0, weights 0; a fresh start after reset runs normally.
